// File: rtl/eaglesong_nonce_driver_if.sv
// Handshake bundle between job dispatch, the nonce driver and one Eaglesong digest core.
// The master modport is the driver's view; slave is the view of everything around it.
interface eaglesong_nonce_driver_if #(
    parameter int NONCE_W = 32
);
    logic                 job_valid;
    logic                 job_ready;
    logic [255-NONCE_W:0] job_prefix;
    logic [255:0]         job_target;
    logic [NONCE_W-1:0]   job_nonce_start;
    logic [NONCE_W-1:0]   job_nonce_count;
    logic                 abort;

    logic [255:0]         dig_input_val;
    logic [6:0]           dig_input_length_bytes;
    logic                 dig_start_eval;
    logic [255:0]         dig_output_val;
    logic                 dig_eval_output_ready;

    logic                 res_valid;
    logic                 res_ready;
    logic                 res_found;
    logic                 res_timeout;
    logic [NONCE_W-1:0]   res_nonce;
    logic [255:0]         res_digest;
    logic                 busy;

    modport master (
        input  job_valid, job_prefix, job_target, job_nonce_start, job_nonce_count, abort,
        input  dig_output_val, dig_eval_output_ready, res_ready,
        output job_ready, dig_input_val, dig_input_length_bytes, dig_start_eval,
        output res_valid, res_found, res_timeout, res_nonce, res_digest, busy
    );

    modport slave (
        output job_valid, job_prefix, job_target, job_nonce_start, job_nonce_count, abort,
        output dig_output_val, dig_eval_output_ready, res_ready,
        input  job_ready, dig_input_val, dig_input_length_bytes, dig_start_eval,
        input  res_valid, res_found, res_timeout, res_nonce, res_digest, busy
    );
endinterface

// File: rtl/eaglesong_nonce_driver.sv
// Walks a nonce range through one Eaglesong core, reporting the first digest below target.
// state  | meaning
// IDLE   | waiting for a job; job_ready high
// START  | one-cycle start pulse, input word already registered
// ARM    | core still shows stale ready from the previous run; ignored
// WAIT   | waiting for core ready, bounded by the timeout down-counter
// CHECK  | compare captured digest, advance nonce or finish
// REPORT | result held until res_ready
module eaglesong_nonce_driver #(
    parameter int NONCE_W        = 32,
    parameter int MSG_BYTES      = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                     clk,
    input  logic                     rst_n,
    eaglesong_nonce_driver_if.master bus
);
    localparam int PFX_W = 256 - NONCE_W;
    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_ARM, S_WAIT, S_CHECK, S_REPORT
    } state_t;

    state_t             state_q;
    logic [PFX_W-1:0]   prefix_q;
    logic [255:0]       target_q;
    logic [255:0]       digest_q;
    logic [NONCE_W-1:0] nonce_q;
    logic [NONCE_W-1:0] remain_q;
    logic [TMR_W-1:0]   tmr_q;
    logic               start_q;
    logic [255:0]       din_q;
    logic               res_found_q;
    logic               res_timeout_q;
    logic [NONCE_W-1:0] res_nonce_q;
    logic [255:0]       res_digest_q;

    logic [NONCE_W-1:0] nonce_inc_d;
    logic [NONCE_W-1:0] remain_dec_d;
    logic               hit_d;

    assign nonce_inc_d  = nonce_q + NONCE_W'(1);
    assign remain_dec_d = remain_q - NONCE_W'(1);
    assign hit_d        = digest_q < target_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            prefix_q      <= '0;
            target_q      <= '0;
            digest_q      <= '0;
            nonce_q       <= '0;
            remain_q      <= '0;
            tmr_q         <= '0;
            start_q       <= 1'b0;
            din_q         <= '0;
            res_found_q   <= 1'b0;
            res_timeout_q <= 1'b0;
            res_nonce_q   <= '0;
            res_digest_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.job_valid) begin
                        prefix_q <= bus.job_prefix;
                        target_q <= bus.job_target;
                        nonce_q  <= bus.job_nonce_start;
                        remain_q <= bus.job_nonce_count;
                        if (bus.job_nonce_count == '0) begin
                            state_q       <= S_REPORT;
                            res_found_q   <= 1'b0;
                            res_timeout_q <= 1'b0;
                            res_nonce_q   <= bus.job_nonce_start;
                            res_digest_q  <= '0;
                        end else begin
                            state_q <= S_START;
                            start_q <= 1'b1;
                            din_q   <= {bus.job_prefix, bus.job_nonce_start};
                        end
                    end
                end
                S_START: begin
                    start_q <= 1'b0;
                    tmr_q   <= TMR_W'(TIMEOUT_CYCLES - 1);
                    state_q <= bus.abort ? S_IDLE : S_ARM;
                end
                S_ARM: begin
                    state_q <= bus.abort ? S_IDLE : S_WAIT;
                end
                S_WAIT: begin
                    // Ready wins over the terminal count: a result on the last allowed cycle is kept.
                    if (bus.abort) begin
                        state_q <= S_IDLE;
                    end else if (bus.dig_eval_output_ready) begin
                        digest_q <= bus.dig_output_val;
                        state_q  <= S_CHECK;
                    end else if (tmr_q == '0) begin
                        state_q       <= S_REPORT;
                        res_found_q   <= 1'b0;
                        res_timeout_q <= 1'b1;
                        res_nonce_q   <= nonce_q;
                        res_digest_q  <= '0;
                    end else begin
                        tmr_q <= tmr_q - TMR_W'(1);
                    end
                end
                S_CHECK: begin
                    if (bus.abort) begin
                        state_q <= S_IDLE;
                    end else if (hit_d || remain_dec_d == '0) begin
                        state_q       <= S_REPORT;
                        res_found_q   <= hit_d;
                        res_timeout_q <= 1'b0;
                        res_nonce_q   <= nonce_q;
                        res_digest_q  <= digest_q;
                    end else begin
                        remain_q <= remain_dec_d;
                        nonce_q  <= nonce_inc_d;
                        din_q    <= {prefix_q, nonce_inc_d};
                        start_q  <= 1'b1;
                        state_q  <= S_START;
                    end
                end
                S_REPORT: begin
                    if (bus.res_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.job_ready              = (state_q == S_IDLE);
    assign bus.busy                   = (state_q != S_IDLE);
    assign bus.res_valid              = (state_q == S_REPORT);
    assign bus.dig_start_eval         = start_q;
    assign bus.dig_input_val          = din_q;
    assign bus.dig_input_length_bytes = 7'(MSG_BYTES);
    assign bus.res_found              = res_found_q;
    assign bus.res_timeout            = res_timeout_q;
    assign bus.res_nonce              = res_nonce_q;
    assign bus.res_digest             = res_digest_q;
endmodule

// File: tb/tb_eaglesong_nonce_driver.sv
// Bench for eaglesong_nonce_driver: behavioural digest core, directed vector table,
// abort/reset/hold sequences and randomized jobs checked against a nonce-range model.
module tb_eaglesong_nonce_driver;
    localparam int NW = 32;
    localparam int TO = 16;
    localparam logic [223:0] KU = 224'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978_8796A5B4;
    localparam logic [255:0] K  = {KU, 32'hFFFF_FFFF};
    localparam logic [223:0] P1 = 224'hDEADBEEF_00112233_44556677_8899AABB_CCDDEEFF_13579BDF_2468ACE0;

    typedef struct {
        logic [223:0] prefix;
        logic [255:0] target;
        logic [31:0]  nstart;
        logic [31:0]  ncount;
        int           lat;
        bit           never;
        bit           hold;
        bit           exp_found;
        bit           exp_timeout;
        logic [31:0]  exp_nonce;
        logic [255:0] exp_digest;
        int           exp_pulses;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    eaglesong_nonce_driver_if #(.NONCE_W(NW)) bus();

    eaglesong_nonce_driver #(.NONCE_W(NW), .MSG_BYTES(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural core: ready drops one edge after start is seen, rises lat edges after start.
    int           core_lat = 4;
    bit           core_never = 1'b0;
    int           core_cnt = 0;
    logic         core_pend = 1'b0;
    logic         core_rdy = 1'b0;
    logic [255:0] core_in = '0;
    logic [255:0] core_dig = '0;
    always @(posedge clk) begin
        if (bus.dig_start_eval) begin
            core_cnt  <= core_lat;
            core_pend <= 1'b1;
            core_in   <= bus.dig_input_val;
        end else begin
            if (core_pend) begin
                core_rdy  <= 1'b0;
                core_pend <= 1'b0;
            end
            if (core_cnt != 0) begin
                core_cnt <= core_cnt - 1;
                if (core_cnt == 1 && !core_never) begin
                    core_rdy <= 1'b1;
                    core_dig <= core_in ^ K;
                end
            end
        end
    end
    assign bus.dig_eval_output_ready = core_rdy;
    assign bus.dig_output_val        = core_dig;

    logic [255:0] dq[$];
    int           pq[$];
    always @(negedge clk) begin
        if (bus.dig_start_eval) begin
            dq.push_back(bus.dig_input_val);
            pq.push_back(cyc);
        end
    end

    task automatic check_v(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_i(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [255:0] dig_of(input logic [223:0] p, input logic [31:0] n);
        return {p, n} ^ K;
    endfunction

    // Reference: try nonces in order until the first digest strictly below target.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        logic [31:0] n;
        r.exp_found = 1'b0; r.exp_timeout = 1'b0; r.exp_nonce = v.nstart;
        r.exp_digest = '0;  r.exp_pulses = 0;
        if (v.ncount == 32'd0) return r;
        if (v.never) begin
            r.exp_timeout = 1'b1; r.exp_pulses = 1;
            return r;
        end
        for (int i = 0; i < int'(v.ncount); i++) begin
            n = 32'(v.nstart + 32'(i));
            r.exp_pulses = i + 1;
            r.exp_nonce  = n;
            r.exp_digest = dig_of(v.prefix, n);
            if (r.exp_digest < v.target) begin
                r.exp_found = 1'b1;
                break;
            end
        end
        return r;
    endfunction

    task automatic check_reset(input string tag);
        check_i({tag, "_job_ready"}, int'(bus.job_ready), 1);
        check_i({tag, "_busy"}, int'(bus.busy), 0);
        check_i({tag, "_start"}, int'(bus.dig_start_eval), 0);
        check_v({tag, "_input_val"}, bus.dig_input_val, '0);
        check_i({tag, "_len"}, int'(bus.dig_input_length_bytes), 32);
        check_i({tag, "_res_valid"}, int'(bus.res_valid), 0);
        check_i({tag, "_res_found"}, int'(bus.res_found), 0);
        check_i({tag, "_res_timeout"}, int'(bus.res_timeout), 0);
        check_v({tag, "_res_nonce"}, 256'(bus.res_nonce), '0);
        check_v({tag, "_res_digest"}, bus.res_digest, '0);
    endtask

    task automatic drive_job(input logic [223:0] p, input logic [255:0] t, input logic [31:0] s,
                             input logic [31:0] c, input int lat, input bit never, output int acc);
        core_lat = lat;
        core_never = never;
        @(posedge clk); #1;
        bus.job_prefix = p; bus.job_target = t;
        bus.job_nonce_start = s; bus.job_nonce_count = c;
        bus.job_valid = 1'b1;
        acc = cyc;
        @(posedge clk); #1;
        bus.job_valid = 1'b0;
    endtask

    task automatic wait_pulse(input string name);
        int n = 0;
        @(negedge clk);
        while (!bus.dig_start_eval && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.dig_start_eval) check_i({name, "_pulse_wait"}, 0, 1);
    endtask

    task automatic run_job(input string name, input vec_t v);
        int acc, rv, np, n, base, bad, exp_gap;
        logic sf, st;
        logic [31:0] sn;
        logic [255:0] sd;
        check_i({name, "_idle"}, int'(bus.job_ready), 1);
        base = dq.size();
        drive_job(v.prefix, v.target, v.nstart, v.ncount, v.lat, v.never, acc);
        @(negedge clk);
        check_i({name, "_job_ready_fall"}, int'(bus.job_ready), 0);
        n = 0;
        while (!bus.res_valid && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check_i({name, "_res_valid"}, int'(bus.res_valid), 1);
        rv = cyc;
        np = dq.size() - base;
        check_i({name, "_found"}, int'(bus.res_found), int'(v.exp_found));
        check_i({name, "_timeout"}, int'(bus.res_timeout), int'(v.exp_timeout));
        check_v({name, "_nonce"}, 256'(bus.res_nonce), 256'(v.exp_nonce));
        check_v({name, "_digest"}, bus.res_digest, v.exp_digest);
        check_i({name, "_pulses"}, np, v.exp_pulses);
        bad = 0;
        exp_gap = 3 + v.lat;
        for (int i = 0; i < np; i++) begin
            if (dq[base+i] !== {v.prefix, 32'(v.nstart + 32'(i))}) bad++;
            if (i > 0 && pq[base+i] - pq[base+i-1] != exp_gap) bad++;
        end
        check_i({name, "_nonce_seq"}, bad, 0);
        if (np == 0) begin
            check_i({name, "_report_lat"}, rv - acc, 1);
        end else begin
            check_i({name, "_first_start_lat"}, pq[base] - acc, 1);
            check_i({name, "_report_lat"}, rv - pq[base+np-1], v.exp_timeout ? TO + 2 : 3 + v.lat);
        end
        if (v.hold) begin
            sf = bus.res_found; st = bus.res_timeout; sn = bus.res_nonce; sd = bus.res_digest;
            base = dq.size();
            @(posedge clk); #1;
            bus.job_nonce_count = 32'd1;
            bus.job_valid = 1'b1;
            bad = 0;
            repeat (10) begin
                @(negedge clk);
                if (!bus.res_valid || bus.job_ready || bus.res_found !== sf || bus.res_timeout !== st ||
                    bus.res_nonce !== sn || bus.res_digest !== sd) bad++;
            end
            check_i({name, "_hold_stable"}, bad + dq.size() - base, 0);
            @(posedge clk); #1;
            bus.job_valid = 1'b0;
        end
        @(posedge clk); #1;
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        @(negedge clk);
        check_i({name, "_report_exit"}, int'({bus.res_valid, bus.job_ready}), 1);
    endtask

    vec_t tbl[6];

    initial begin
        int acc, base, bad;
        vec_t v;
        bus.job_valid = 1'b0; bus.abort = 1'b0; bus.res_ready = 1'b0;
        bus.job_prefix = '0; bus.job_target = '0; bus.job_nonce_start = '0; bus.job_nonce_count = '0;

        tbl[0] = '{prefix: '0, target: {KU, 32'hFFFF_FFFB}, nstart: 32'h0, ncount: 32'h10, lat: 16,
                   never: 1'b0, hold: 1'b1, exp_found: 1'b1, exp_timeout: 1'b0, exp_nonce: 32'h5,
                   exp_digest: {KU, 32'hFFFF_FFFA}, exp_pulses: 6};
        tbl[1] = '{prefix: P1, target: '0, nstart: 32'hFFFF_FFFE, ncount: 32'd3, lat: 3,
                   never: 1'b0, hold: 1'b0, exp_found: 1'b0, exp_timeout: 1'b0, exp_nonce: 32'h0,
                   exp_digest: {P1 ^ KU, 32'hFFFF_FFFF}, exp_pulses: 3};
        tbl[2] = '{prefix: P1, target: '1, nstart: 32'h1234_5678, ncount: 32'd0, lat: 3,
                   never: 1'b0, hold: 1'b0, exp_found: 1'b0, exp_timeout: 1'b0, exp_nonce: 32'h1234_5678,
                   exp_digest: '0, exp_pulses: 0};
        tbl[3] = '{prefix: P1, target: '1, nstart: 32'h0000_ABCD, ncount: 32'd5, lat: 3,
                   never: 1'b1, hold: 1'b0, exp_found: 1'b0, exp_timeout: 1'b1, exp_nonce: 32'h0000_ABCD,
                   exp_digest: '0, exp_pulses: 1};
        tbl[4] = '{prefix: P1, target: {P1 ^ KU, 32'hFFFF_FFF8}, nstart: 32'd7, ncount: 32'd1, lat: 2,
                   never: 1'b0, hold: 1'b0, exp_found: 1'b0, exp_timeout: 1'b0, exp_nonce: 32'd7,
                   exp_digest: {P1 ^ KU, 32'hFFFF_FFF8}, exp_pulses: 1};
        tbl[5] = '{prefix: P1, target: {P1 ^ KU, 32'hFFFF_FFF9}, nstart: 32'd7, ncount: 32'd1, lat: 2,
                   never: 1'b0, hold: 1'b0, exp_found: 1'b1, exp_timeout: 1'b0, exp_nonce: 32'd7,
                   exp_digest: {P1 ^ KU, 32'hFFFF_FFF8}, exp_pulses: 1};

        repeat (2) @(negedge clk);
        check_reset("rst_init");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_job($sformatf("vec%0d", i), tbl[i]);

        drive_job(P1, '0, 32'h0, 32'd16, 16, 1'b0, acc);
        wait_pulse("abort_wait");
        repeat (5) @(negedge clk);
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        @(negedge clk);
        check_i("abort_wait_idle", int'({bus.busy, bus.job_ready}), 1);
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.res_valid || bus.dig_start_eval) bad++;
        end
        check_i("abort_wait_quiet", bad, 0);
        run_job("after_abort1", tbl[5]);

        drive_job(P1, '0, 32'd100, 32'd16, 4, 1'b0, acc);
        wait_pulse("abort_rdy");
        repeat (5) @(negedge clk);
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        @(negedge clk);
        check_i("abort_rdy_idle", int'({bus.busy, bus.res_valid}), 0);
        run_job("after_abort2", tbl[4]);

        for (int j = 0; j < 25; j++) begin
            v.prefix = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            v.nstart = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 4)) : $urandom();
            v.ncount = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 8));
            v.lat = int'($urandom_range(2, 16));
            v.never = 1'b0;
            v.hold = 1'b0;
            if ($urandom_range(0, 4) == 0)
                v.target = {$urandom(), $urandom(), $urandom(), $urandom(),
                            $urandom(), $urandom(), $urandom(), $urandom()};
            else
                v.target = dig_of(v.prefix, 32'(v.nstart + 32'($urandom_range(0, 9))))
                           + 256'($urandom_range(0, 1));
            v = model(v);
            run_job($sformatf("rnd%0d", j), v);
        end

        drive_job(P1, '0, 32'h0, 32'd4, 16, 1'b0, acc);
        wait_pulse("rst_mid");
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        base = dq.size();
        repeat (30) @(negedge clk);
        check_i("rst_mid_no_start", dq.size() - base, 0);
        check_i("rst_mid_idle", int'(bus.busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
